// File: rtl/fir_out_decimator.sv
// fir_out_decimator: block-averages the FIR result by 2^LOG2_DEC samples.
// The result is gain-shifted, saturated to OUT_SIZE bits and sent on a
// valid/ready port.
// Ports: clk, reset (sync, active-high); y_n/y_valid sample input;
// m_tdata/m_tvalid/m_tready output port; sat_flag/drop_flag sticky flags.
module fir_out_decimator #(
  parameter int Y_N_SIZE   = 11,
  parameter int OUT_SIZE   = 8,
  parameter int LOG2_DEC   = 2,
  parameter int GAIN_SHIFT = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [Y_N_SIZE-1:0] y_n,
  input  logic                       y_valid,
  output logic signed [OUT_SIZE-1:0] m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       sat_flag,
  output logic                       drop_flag
);

  localparam int N     = 1 << LOG2_DEC;
  localparam int ACC_W = Y_N_SIZE + LOG2_DEC;
  localparam int SH    = LOG2_DEC + GAIN_SHIFT;

  localparam logic [LOG2_DEC-1:0] CNT_ONE  = LOG2_DEC'(1);
  localparam logic [LOG2_DEC-1:0] CNT_LAST = LOG2_DEC'(N - 1);

  localparam logic [OUT_SIZE-1:0] OUT_MAX =
    {1'b0, {(OUT_SIZE-1){1'b1}}};
  localparam logic [OUT_SIZE-1:0] OUT_MIN =
    {1'b1, {(OUT_SIZE-1){1'b0}}};

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t                     state, state_n;
  logic signed [ACC_W-1:0]    acc, acc_n;
  logic [LOG2_DEC-1:0]        cnt, cnt_n;
  logic signed [ACC_W-1:0]    y_ext;
  logic signed [ACC_W-1:0]    total;
  logic signed [ACC_W-1:0]    q;
  logic [ACC_W-OUT_SIZE:0]    q_hi;
  logic                       done;
  logic                       clamp;
  logic [OUT_SIZE-1:0]        res;

  assign y_ext = {{LOG2_DEC{y_n[Y_N_SIZE-1]}}, y_n};
  assign total = acc + y_ext;
  assign q     = total >>> SH;

  // q fits the output when every bit above the output sign bit
  // matches it.
  assign q_hi  = q[ACC_W-1:OUT_SIZE-1];
  assign clamp = !((&q_hi) || !(|q_hi));

  always_comb begin
    res = q[OUT_SIZE-1:0];
    if (clamp) begin
      res = q[ACC_W-1] ? OUT_MIN : OUT_MAX;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (y_valid) begin
          acc_n   = y_ext;
          cnt_n   = CNT_ONE;
          state_n = ACCUM;
        end
      end
      ACCUM: begin
        if (!y_valid) begin
          // A gap in the stream throws away the partial block.
          acc_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          done  = 1'b1;
          acc_n = '0;
          cnt_n = '0;
        end else begin
          acc_n = total;
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      if (done && clamp) begin
        sat_flag <= 1'b1;
      end
      unique case (1'b1)
        done && (!m_tvalid || m_tready): begin
          m_tdata  <= res;
          m_tvalid <= 1'b1;
        end
        done && m_tvalid && !m_tready: begin
          drop_flag <= 1'b1;
        end
        !done && m_tvalid && m_tready: begin
          m_tvalid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/fir_out_decimator.md
# fir_out_decimator

Output stage directly downstream of the FIR filter. Consumes the signed filter result `y_n` while the filter is active, block-averages it by 2^LOG2_DEC samples, applies a gain shift and saturation to an 8-bit result, and presents it on a valid/ready output port sized for the Tiny Tapeout output pins. Sticky flags report saturation and results dropped under backpressure.

## Interface
- `Y_N_SIZE`, 11: width of the signed input sample; must match the FIR output width.
- `OUT_SIZE`, 8: width of the signed output sample.
- `LOG2_DEC`, 2: log2 of the decimation factor. N = 2^LOG2_DEC; legal range 1..4.
- `GAIN_SHIFT`, 0: extra arithmetic right shift applied after averaging; legal range 0..3.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `y_n`  in  Y_N_SIZE  signed filter output sample.
- `y_valid`  in  1  high when `y_n` carries a valid sample (FIR in ACTIVE); one sample per cycle while high.
- `m_tdata`  out  OUT_SIZE  signed decimated result.
- `m_tvalid`  out  1  `m_tdata` holds an untaken result.
- `m_tready`  in  1  downstream accepts `m_tdata` this cycle.
- `sat_flag`  out  1  sticky; set when any result was clamped.
- `drop_flag`  out  1  sticky; set when any result was discarded due to backpressure.

## Operation
- Accumulator `acc` is signed, Y_N_SIZE+LOG2_DEC bits. Inputs are sign-extended; the accumulator cannot overflow.
- Sample counter `cnt` is LOG2_DEC bits.
- FSM states:
  - IDLE: `cnt`=0, `acc`=0. If `y_valid`=1: `acc`<=`y_n`, `cnt`<=1, go to ACCUM.
  - ACCUM, when `y_valid`=1 and `cnt`<N-1: `acc`+=`y_n`, `cnt`++.
  - ACCUM, when `y_valid`=1 and `cnt`=N-1: `total`=`acc`+`y_n` is complete. Clear `acc` and `cnt`, stay in ACCUM.
  - ACCUM, when `y_valid`=0: discard the partial block. Clear `acc` and `cnt`, go to IDLE. No result is produced from a partial block.
- Result arithmetic:
  - q = `total` >>> (LOG2_DEC+GAIN_SHIFT). The shift is arithmetic and truncates toward minus infinity.
  - Clamp q to [-2^(OUT_SIZE-1), 2^(OUT_SIZE-1)-1]. If clamping occurs, set `sat_flag`.
- Output register:
  - A completed result loads `m_tdata` and sets `m_tvalid` when `m_tvalid`=0, or when `m_tvalid`=1 and `m_tready`=1 in that cycle (back-to-back transfer).
  - A completed result with `m_tvalid`=1 and `m_tready`=0 is discarded. `drop_flag` is set; `m_tdata` and `m_tvalid` are unchanged.
  - `m_tvalid`=1 and `m_tready`=1 with no new result: clear `m_tvalid`. `m_tdata` holds its last value.
  - `m_tdata` is stable while `m_tvalid`=1 and `m_tready`=0.
- Flags clear only on `reset`.

## Timing
- Reset values: `m_tdata`=0, `m_tvalid`=0, `sat_flag`=0, `drop_flag`=0, `acc`=0, `cnt`=0, state IDLE.
- Reset overrides all other activity, including mid-block or with `m_tvalid`=1. A pending result is lost without setting `drop_flag`.
- Latency: the N-th sample is sampled at rising edge E. `m_tvalid` and `m_tdata` update at edge E, visible in the following cycle. This is 1 cycle after the last sample.
- Throughput: one result per N valid cycles. With `m_tready` held high, no result is dropped. The minimum `m_tvalid` pulse is 1 cycle.
- `y_valid` low for a single cycle is enough to flush a partial block.
- Simultaneous block completion and `m_tready`=1 is a legal back-to-back transfer, not a drop.

## Test plan
All scenarios use defaults (N=4, GAIN_SHIFT=0) unless stated.
- Basic average: `m_tready`=1, `y_valid`=1 for 4 cycles, `y_n`=10,20,30,40 -> `m_tdata`=25, `m_tvalid` high 1 cycle, starting 1 cycle after the 4th sample. Flags stay 0.
- Saturation:
  - `y_n`=1023 ×4 -> `m_tdata`=127, `sat_flag`=1.
  - After reset, `y_n`=-1024 ×4 -> `m_tdata`=-128, `sat_flag`=1.
  - `y_n`=100 ×4 with GAIN_SHIFT=0 -> 100, no saturation.
- Rounding: `y_n`=-5 ×4 -> -5. `y_n`=-1,-1,-1,0 -> -1 (floor). `y_n`=1,1,1,0 -> 0.
- Partial flush: 3 samples of 50, then `y_valid`=0 for 1 cycle, then 4 samples of 8 -> exactly one result, `m_tdata`=8.
- Backpressure:
  - `m_tready`=0, 8 consecutive samples of 3 -> first result 3 is held with `m_tvalid`=1; second result is dropped and `drop_flag`=1.
  - Then raise `m_tready` -> 3 is taken and `m_tvalid` falls.
  - Separately, completion in the same cycle as `m_tready`=1 -> new value loads, `drop_flag` stays 0.
- Reset mid-operation: 2 samples of 100, assert `reset` 1 cycle, then 4 samples of 4 -> single output 4. All flags 0. No output contains the pre-reset samples.
